// File: rtl/output_buffer_logic_pkg.sv
// Shared types and constants for the router egress buffer.
package output_buffer_logic_pkg;

   localparam int BYTES_PER_PKT = 4;

   typedef logic [BYTES_PER_PKT-1:0][7:0] pkt_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } obuf_state_t;

   // Bursts start at the most significant byte.
   localparam logic [1:0] LAST_BYTE_PTR = 2'(BYTES_PER_PKT - 1);

endpackage

// File: rtl/output_buffer_logic_pkt_fifo.sv
// Whole-packet queue for the egress buffer; push/pop are ignored when full/empty.
module pkt_fifo
   import output_buffer_logic_pkg::*;
#(
   parameter int PKT_DEPTH = 2,
   localparam int PTR_W = $clog2(PKT_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  pkt_t             wr_data,
   input  logic             pop,
   output pkt_t             head,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   pkt_t             mem_q [PKT_DEPTH];
   pkt_t             mem_d [PKT_DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Fullness is judged on the registered count, so a pop never frees a slot for a same-edge push.
   assign full    = (count_q == CNT_W'(PKT_DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage holds no control state, so it is left out of reset.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/output_buffer_logic.sv
// Router egress port: queues whole packets and serialises each as a 4-byte burst, byte 3 first.
// Optional packet counter port pkt_sent_count is built when OUTBUF_STATS_EN is defined.
//
// state | meaning
// IDLE  | no burst; starts one when a packet is queued and node_free is high
// SEND  | driving head[byte_ptr] with put_outbound high; pops head after byte 0
module output_buffer_logic
   import output_buffer_logic_pkg::*;
#(
   parameter int PKT_DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            route_valid,
   input  logic [3:0][7:0] route_data,
   output logic            route_ready,
   input  logic            node_free,
   output logic            put_outbound,
   output logic [7:0]      payload_outbound,
   output logic            output_buffer_empty
`ifdef OUTBUF_STATS_EN
   ,
   output logic [15:0]     pkt_sent_count
`endif
);

   localparam int CNT_W = $clog2(PKT_DEPTH) + 1;

   obuf_state_t      state_q, state_d;
   logic [1:0]       byte_ptr_q, byte_ptr_d;
   logic             put_q, put_d;
   logic [7:0]       payload_q, payload_d;
   logic             pop;
   logic             push;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   pkt_t             head;
   pkt_t             wr_data;

   assign wr_data     = route_data;
   assign route_ready = !fifo_full;
   assign push        = route_valid && route_ready;

   pkt_fifo #(
      .PKT_DEPTH (PKT_DEPTH)
   ) u_pkt_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .wr_data (wr_data),
      .pop     (pop),
      .head    (head),
      .count   (fifo_count),
      .full    (fifo_full)
   );

   // Outputs are registered alongside the state so strobe and byte change on the same edge.
   always_comb begin
      state_d    = state_q;
      byte_ptr_d = byte_ptr_q;
      put_d      = 1'b0;
      payload_d  = 8'h00;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if ((fifo_count != '0) && node_free) begin
               state_d    = SEND;
               byte_ptr_d = LAST_BYTE_PTR;
               put_d      = 1'b1;
               payload_d  = head[LAST_BYTE_PTR];
            end
         end
         SEND: begin
            if (byte_ptr_q == 2'd0) begin
               pop        = 1'b1;
               state_d    = IDLE;
               byte_ptr_d = LAST_BYTE_PTR;
            end else begin
               byte_ptr_d = byte_ptr_q - 2'd1;
               put_d      = 1'b1;
               payload_d  = head[byte_ptr_d];
            end
         end
         default: begin
            state_d    = IDLE;
            byte_ptr_d = LAST_BYTE_PTR;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         byte_ptr_q <= LAST_BYTE_PTR;
         put_q      <= 1'b0;
         payload_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         byte_ptr_q <= byte_ptr_d;
         put_q      <= put_d;
         payload_q  <= payload_d;
      end
   end

   assign put_outbound        = put_q;
   assign payload_outbound    = payload_q;
   assign output_buffer_empty = (fifo_count == '0) && (state_q == IDLE);

`ifdef OUTBUF_STATS_EN
   logic [15:0] pkt_sent_count_q, pkt_sent_count_d;

   always_comb begin
      pkt_sent_count_d = pkt_sent_count_q;
      if (pop && (pkt_sent_count_q != 16'hFFFF)) begin
         pkt_sent_count_d = pkt_sent_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pkt_sent_count_q <= 16'h0000;
      end else begin
         pkt_sent_count_q <= pkt_sent_count_d;
      end
   end

   assign pkt_sent_count = pkt_sent_count_q;
`endif

endmodule

// File: doc/output_buffer_logic.md
Name: output_buffer_logic

Overview:
Egress side of a router port: accepts whole 4-byte packets from the router core, queues them, and serialises each packet byte-by-byte onto a node link. Uses the node-link framing: a 4-cycle contiguous burst with byte 3 first and byte 0 last. Sits between the routing crossbar output and the attached node's inbound interface.

Parameters:
PKT_DEPTH, 2, number of whole packets the queue holds (power of two, >=2)

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
route_valid  input  1  router presents a packet on route_data this cycle
route_data  input  [3:0][7:0]  packet from router; [3] sent first
route_ready  output  1  queue can accept a packet this cycle
node_free  input  1  attached node able to start receiving a packet
put_outbound  output  1  byte on payload_outbound is valid (burst strobe)
payload_outbound  output  8  serialised packet byte
output_buffer_empty  output  1  queue empty and no burst in progress

Behaviour:
- One clock domain; reset_n synchronous, active-low, sampled on posedge clock.
- Reset values: put_outbound=0, payload_outbound=8'h00, queue count=0, read/write pointers=0, state=IDLE, byte pointer=3, output_buffer_empty=1, route_ready=1.
- route_ready = (count != PKT_DEPTH), combinational from registered count only; it never depends on route_valid.
- Push: route_valid && route_ready at an edge writes route_data at the write pointer, and the write pointer increments modulo PKT_DEPTH.
- route_valid while full: the packet is not captured and no state changes. The router must hold it.
- FSM, two states:
  - IDLE: put_outbound=0, payload_outbound=0. At an edge with count!=0 && node_free: go to SEND, byte pointer=3.
  - SEND: put_outbound=1, payload_outbound=head[byte pointer]. Registered, so the byte and strobe appear together. Each edge decrements the byte pointer.
  - Leaving SEND: at the edge with byte pointer==0, pop the head (read pointer +1 mod PKT_DEPTH, count-1), return to IDLE, reset byte pointer to 3.
- Latency: packet pushed at edge N into an empty queue with node_free=1 gives put_outbound high for cycles N+1..N+4, carrying bytes 3,2,1,0.
- Minimum one idle cycle (put_outbound=0) between consecutive bursts.
- node_free is sampled only in IDLE. Deasserting it mid-burst has no effect; the burst always completes as 4 contiguous cycles.
- Simultaneous push and pop at the same edge: count unchanged, both pointers advance. Push is allowed at that edge only if route_ready was already 1 before the edge (no same-cycle credit from the pop).
- Pointer wrap: pointers are log2(PKT_DEPTH) bits and wrap naturally.
- count is log2(PKT_DEPTH)+1 bits; it never exceeds PKT_DEPTH and never underflows.
- output_buffer_empty = (count==0) && (state==IDLE).
- Reset mid-burst: the burst is abandoned, put_outbound=0 at the next edge, and all queued packets are discarded.

Optional Feature:
Macro: OUTBUF_STATS_EN.
- Defined:
  - Adds output port pkt_sent_count [15:0]: increments on each burst completion (the pop edge).
  - Saturates at 16'hFFFF.
  - Reset to 0 by reset_n.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- RouterPkg additions:
  - typedef pkt_t = logic [3:0][7:0].
  - Constant BYTES_PER_PKT=4.
  - Enum obuf_state_t {IDLE, SEND}.
- Sub-module pkt_fifo (PKT_DEPTH-deep queue of pkt_t):
  - Inputs: push, pop.
  - Outputs: head, count, full.
- output_buffer_logic holds the FSM, byte pointer, output registers and the stats counter.

Test Plan:
1. Reset, then push 32'hA1B2C3D4 with node_free=1 -> put_outbound high cycles N+1..N+4 with payload A1,B2,C3,D4. Afterwards put_outbound=0 and output_buffer_empty=1.
2. node_free=0, push two packets (11223344, 55667788) -> route_ready=0 after the second push. A third route_valid is not captured and no put_outbound occurs. Then raise node_free -> 11,22,33,44, one idle cycle, then 55,66,77,88.
3. Drop node_free in the 2nd cycle of a burst of 0xDEADBEEF -> all four bytes DE,AD,BE,EF still sent contiguously. No new burst starts until node_free=1 in IDLE.
4. Queue full and route_valid held high across the pop edge -> no capture at the pop edge. Capture occurs at the next edge (route_ready=1); count returns to PKT_DEPTH.
5. Assert reset_n=0 after 2 bytes of a burst -> next edge put_outbound=0, payload 00, output_buffer_empty=1, route_ready=1. The partial packet is never resumed.
6. OUTBUF_STATS_EN defined, send 3 packets -> pkt_sent_count=3. Force the counter to 16'hFFFE and send 2 packets -> holds 16'hFFFF.
